wr_stream_arbiter: RTL and testbench
====================================

// Module: wr_stream_arbiter
// PURPOSE
// - Shares the single write-data byte stream (8-bit data/empty/re, from the Write FIFO interface) among NUM_CH flash channel controllers.
// - Grants one channel at a time, round-robin, for an atomic burst of exactly BURST_BYTES bytes.
// - Routes that channel's read strobe upstream and reports completion.
// - Sits between the Write FIFO interface and the per-channel controllers.
// PARAMETERS
// - NUM_CH       4   number of requesting channel controllers (>=2)
// - BURST_BYTES  16  bytes per grant (one 128-bit Write FIFO word = 16; >=2)
// - CNT_W        derived localparam = log2(BURST_BYTES) (at least 1); width of the byte counter
// PORTS
// - i_clk           in   1             system clock; single clock domain
// - i_rst           in   1             asynchronous, active-high reset
// - i_src_data      in   8             byte from the write stream source
// - i_src_empty     in   1             source has no valid byte
// - o_src_re        out  1             consume current source byte (combinational)
// - i_ch_req        in   NUM_CH        per-channel burst request (level)
// - i_ch_re         in   NUM_CH        per-channel byte read strobe
// - o_ch_data       out  8             byte broadcast to all channels (= i_src_data)
// - o_ch_empty      out  NUM_CH        per-channel empty; 1 unless the channel is granted and the source has data
// - o_grant         out  NUM_CH        one-hot registered grant
// - o_done          out  NUM_CH        one-cycle pulse on burst completion, to the granted channel
// - o_busy          out  1             1 while a burst is granted (XFER or DONE)
// - o_byte_cnt      out  CNT_W         bytes accepted in the current burst
// BEHAVIOUR
// Reset (async, i_rst=1):
// - state=IDLE; o_grant=0; o_done=0; o_busy=0; o_byte_cnt=0.
// - last_ptr=NUM_CH-1, so channel 0 has first priority.
// - o_ch_empty is all ones and o_src_re=0 while in reset.
// - Reset mid-burst abandons the burst silently: no o_done, and the partial byte count is lost.
// State IDLE:
// - o_grant=0, all o_ch_empty=1, o_src_re=0.
// - If any i_ch_req is set, select the first requesting channel searching (last_ptr+1) mod NUM_CH upward with wrap.
// - Register the selection into o_grant and set byte_cnt=0. Go to XFER.
// - Latency: request sampled in cycle k gives o_grant in cycle k+1.
// State XFER (granted channel g):
// - o_ch_empty[g]=i_src_empty.
// - o_src_re = i_ch_re[g] & ~i_src_empty.
// - A byte is accepted in every cycle where o_src_re=1.
// - Each accepted byte increments byte_cnt.
// - The accepted byte with byte_cnt==BURST_BYTES-1 ends the burst: go to DONE; the counter wraps to 0.
// - i_ch_re of non-granted channels is ignored: no source read, no count change.
// - i_ch_re[g] while the source is empty is ignored: no count change, burst continues.
// - Deasserting i_ch_req[g] mid-burst does not end the burst; the burst is atomic.
// State DONE (one cycle):
// - o_done[g]=1; o_grant still =g.
// - o_src_re=0 and all o_ch_empty=1.
// - last_ptr<=g. Go to IDLE.
// - Next grant appears no earlier than 2 cycles after DONE.
// Requests:
// - A request present in IDLE is served.
// - Simultaneous requests resolve strictly by round-robin order from last_ptr+1.
// - A channel still requesting after its DONE is served again only if no other channel is requesting.
// - No starvation: any channel holding i_ch_req is granted within NUM_CH-1 intervening bursts.
// Widths:
// - byte_cnt is CNT_W bits and never exceeds BURST_BYTES-1.
// - o_grant and o_done are always one-hot or zero; never two bits set.
// TESTING
// - Reset, then i_ch_req=4'b0100 -> o_grant=4'b0100 one cycle later; 16 strobes with the source never empty -> o_done[2] pulses exactly once; o_src_re high 16 cycles.
// - i_ch_req=4'b1111 held -> grant order 0,1,2,3,0; each burst is 16 bytes; o_done pulses in the same order.
// - Source empty for 5 cycles mid-burst while i_ch_re[g]=1 -> o_src_re=0, o_byte_cnt frozen; burst completes at 16 accepted bytes.
// - Non-granted channel strobes i_ch_re during another burst -> o_src_re=0 for those cycles, count unaffected, its o_ch_empty=1.
// - i_ch_req[g] dropped after 3 bytes -> grant held, burst completes normally with o_done.
// - i_rst pulsed asynchronously at byte 7 -> outputs return to reset values immediately; no o_done; next grant goes to channel 0 if requesting.

Source files
------------

// File: rtl/wr_stream_arbiter.sv
// Round-robin arbiter that shares one write-data byte stream among NUM_CH
// flash channel controllers. Each grant is an atomic burst of BURST_BYTES bytes.
module wr_stream_arbiter #(
   parameter int  NUM_CH      = 4,
   parameter int  BURST_BYTES = 16,
   localparam int CNT_W       = (BURST_BYTES > 1) ? $clog2(BURST_BYTES) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_src_data,
   input  logic              i_src_empty,
   output logic              o_src_re,
   input  logic [NUM_CH-1:0] i_ch_req,
   input  logic [NUM_CH-1:0] i_ch_re,
   output logic [7:0]        o_ch_data,
   output logic [NUM_CH-1:0] o_ch_empty,
   output logic [NUM_CH-1:0] o_grant,
   output logic [NUM_CH-1:0] o_done,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_byte_cnt
);

   localparam int PTR_W = $clog2(NUM_CH);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t            state;
   logic [PTR_W-1:0]  last_ptr;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W-1:0]  sel_idx;
   logic              sel_found;
   logic [NUM_CH-1:0] sel_onehot;
   logic              accept;
   logic              last_byte;
   int                pos;

   // Round-robin search: first requester starting at last_ptr+1 with wrap.
   // Scanning from the far end down lets the nearest requester win.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      pos        = 0;
      for (int i = NUM_CH; i >= 1; i--) begin
         pos = (int'(last_ptr) + i) % NUM_CH;
         if (i_ch_req[PTR_W'(pos)]) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'(pos);
         end
      end
      sel_onehot          = '0;
      sel_onehot[sel_idx] = sel_found;
   end

   // A byte moves only when the granted channel strobes and the source has data.
   assign accept    = (state == XFER) & i_ch_re[gnt_idx] & ~i_src_empty;
   assign last_byte = (o_byte_cnt == CNT_W'(BURST_BYTES - 1));
   assign o_src_re  = accept;
   assign o_ch_data = i_src_data;

   // Only the granted channel, and only during XFER, sees the source empty flag.
   always_comb begin
      o_ch_empty = '1;
      if (state == XFER) o_ch_empty[gnt_idx] = i_src_empty;
   end

   // Grant FSM: IDLE picks a channel, XFER counts bytes, DONE pulses completion.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         o_grant    <= '0;
         o_done     <= '0;
         o_busy     <= 1'b0;
         o_byte_cnt <= '0;
         gnt_idx    <= '0;
         last_ptr   <= PTR_W'(NUM_CH - 1);
      end else begin
         case (state)
            IDLE: begin
               o_done <= '0;
               if (sel_found) begin
                  o_grant    <= sel_onehot;
                  gnt_idx    <= sel_idx;
                  o_byte_cnt <= '0;
                  o_busy     <= 1'b1;
                  state      <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  if (last_byte) begin
                     o_byte_cnt <= '0;
                     o_done     <= o_grant;
                     state      <= DONE;
                  end else begin
                     o_byte_cnt <= o_byte_cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               o_done   <= '0;
               o_grant  <= '0;
               o_busy   <= 1'b0;
               last_ptr <= gnt_idx;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wr_stream_arbiter.sv
// Scoreboard bench for wr_stream_arbiter: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT shows them.
module tb_wr_stream_arbiter;

   localparam int NUM_CH      = 4;
   localparam int BURST_BYTES = 16;
   localparam int CNT_W       = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        src_byte;
   logic              src_empty;
   logic              src_re;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] ch_re;
   logic [7:0]        ch_data;
   logic [NUM_CH-1:0] ch_empty;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] done;
   logic              busy;
   logic [CNT_W-1:0]  byte_cnt;

   logic              auto_re;
   logic [NUM_CH-1:0] stray_re;

   int n_cmp    = 0;
   int n_err    = 0;
   int done_cnt = 0;

   logic [NUM_CH-1:0] exp_grant_q[$];
   logic [NUM_CH-1:0] exp_done_q[$];

   wr_stream_arbiter #(.NUM_CH(NUM_CH), .BURST_BYTES(BURST_BYTES)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_src_data (src_byte),
      .i_src_empty(src_empty),
      .o_src_re   (src_re),
      .i_ch_req   (req),
      .i_ch_re    (ch_re),
      .o_ch_data  (ch_data),
      .o_ch_empty (ch_empty),
      .o_grant    (grant),
      .o_done     (done),
      .o_busy     (busy),
      .o_byte_cnt (byte_cnt)
   );

   always #5 clk = ~clk;

   // Granted channel strobes continuously when auto_re is set; stray_re adds extra strobes.
   assign ch_re = (grant & {NUM_CH{auto_re}}) | stray_re;

   // Source model: a byte counter that advances on every consumed byte.
   always @(posedge clk or posedge rst)
      if (rst) src_byte <= 8'h00;
      else if (src_re) src_byte <= src_byte + 8'h01;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: pops expectations on each new grant and each done pulse.
   initial begin : monitor
      logic [NUM_CH-1:0] prev_grant;
      int acc;
      prev_grant = '0;
      acc = 0;
      forever begin
         @(negedge clk);
         if (grant != '0 && grant != prev_grant) begin
            acc = 0;
            if (exp_grant_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_grant: got %0h expected none", grant);
            end else check("grant_order", grant, exp_grant_q.pop_front());
         end
         if (src_re) acc++;
         if (done != '0) begin
            done_cnt++;
            if (exp_done_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_done: got %0h expected none", done);
            end else begin
               check("done_chan", done, exp_done_q.pop_front());
               check("done_grant", grant, done);
               check("burst_bytes", acc, BURST_BYTES);
            end
         end
         prev_grant = grant;
      end
   end

   task automatic wait_dones(input int n);
      int target;
      int k;
      target = done_cnt + n;
      k = 0;
      while (done_cnt < target && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      if (done_cnt < target) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, target);
      end
   endtask

   task automatic push_exp(input logic [NUM_CH-1:0] g);
      exp_grant_q.push_back(g);
      exp_done_q.push_back(g);
   endtask

   initial begin
      // Reset state, with every input trying to provoke activity
      rst = 1'b1; req = 4'b1111; src_empty = 1'b0; auto_re = 1'b0; stray_re = 4'b1111;
      repeat (3) @(posedge clk); #1;
      check("rst_grant", grant, 4'b0000);
      check("rst_done", done, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_cnt", byte_cnt, 4'd0);
      check("rst_empty", ch_empty, 4'b1111);
      check("rst_src_re", src_re, 1'b0);
      req = '0; stray_re = '0; rst = 1'b0;
      @(posedge clk); #1;

      // Single request on channel 2
      auto_re = 1'b1;
      push_exp(4'b0100);
      req = 4'b0100;
      check("t1_pre_grant", grant, 4'b0000);
      @(posedge clk); #1;
      check("t1_grant", grant, 4'b0100);
      check("t1_busy", busy, 1'b1);
      check("t1_src_re", src_re, 1'b1);
      check("t1_data", ch_data, src_byte);
      req = '0;
      wait_dones(1);
      check("t1_release", grant, 4'b0000);
      check("t1_idle_busy", busy, 1'b0);

      // Fresh reset, then all four requesting: 0,1,2,3,0
      rst = 1'b1; #2; rst = 1'b0;
      @(posedge clk); #1;
      push_exp(4'b0001); push_exp(4'b0010); push_exp(4'b0100); push_exp(4'b1000); push_exp(4'b0001);
      req = 4'b1111;
      wait_dones(5);
      req = '0;
      repeat (3) @(posedge clk); #1;
      check("t2_idle", grant, 4'b0000);

      // Source runs dry for 5 cycles after 4 bytes
      push_exp(4'b0001);
      req = 4'b0001;
      @(posedge clk); #1;
      check("t3_grant", grant, 4'b0001);
      req = '0;
      repeat (4) @(posedge clk); #1;
      check("t3_cnt4", byte_cnt, 4'd4);
      src_empty = 1'b1; #1;
      check("t3_src_re_empty", src_re, 1'b0);
      check("t3_ch_empty", ch_empty, 4'b1111);
      repeat (5) @(posedge clk); #1;
      check("t3_cnt_frozen", byte_cnt, 4'd4);
      check("t3_busy", busy, 1'b1);
      src_empty = 1'b0;
      wait_dones(1);

      // Non-granted channels strobe while channel 1 holds the grant
      auto_re = 1'b0;
      push_exp(4'b0010);
      req = 4'b0010;
      @(posedge clk); #1;
      check("t5_grant", grant, 4'b0010);
      req = '0;
      stray_re = 4'b1101; #1;
      check("t5_src_re", src_re, 1'b0);
      check("t5_ch_empty", ch_empty, 4'b1101);
      repeat (3) @(posedge clk); #1;
      check("t5_cnt", byte_cnt, 4'd0);
      stray_re = '0; auto_re = 1'b1;
      wait_dones(1);

      // Request withdrawn after 3 bytes; burst still completes
      push_exp(4'b1000);
      req = 4'b1000;
      @(posedge clk); #1;
      check("t6_grant", grant, 4'b1000);
      repeat (3) @(posedge clk); #1;
      check("t6_cnt3", byte_cnt, 4'd3);
      req = '0;
      repeat (5) @(posedge clk); #1;
      check("t6_grant_held", grant, 4'b1000);
      check("t6_cnt8", byte_cnt, 4'd8);
      wait_dones(1);

      // Asynchronous reset at byte 7 of a channel-2 burst
      exp_grant_q.push_back(4'b0100);
      req = 4'b0100;
      @(posedge clk); #1;
      check("t7_grant", grant, 4'b0100);
      repeat (7) @(posedge clk); #1;
      check("t7_cnt7", byte_cnt, 4'd7);
      req = 4'b0101;
      #2; rst = 1'b1; #1;
      check("t7_rst_grant", grant, 4'b0000);
      check("t7_rst_done", done, 4'b0000);
      check("t7_rst_busy", busy, 1'b0);
      check("t7_rst_cnt", byte_cnt, 4'd0);
      check("t7_rst_empty", ch_empty, 4'b1111);
      check("t7_rst_src_re", src_re, 1'b0);
      push_exp(4'b0001);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("t7_regrant", grant, 4'b0001);
      req = '0;
      wait_dones(1);

      repeat (5) @(posedge clk); #1;
      check("left_grants", exp_grant_q.size(), 0);
      check("left_dones", exp_done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
